// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - write-back staging queue feeding the register file write port
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             AluValid,
  input  logic [AW-1:0]    AluDst,
  input  logic [DW-1:0]    AluDat,
  output logic             AluReady,
  input  logic             MemValid,
  input  logic [AW-1:0]    MemDst,
  input  logic [DW-1:0]    MemDat,
  output logic             Wen,
  output logic [AW-1:0]    Wd,
  output logic [DW-1:0]    Wdat,
  output logic [2**AW-1:0] Busy,
  input  logic [AW-1:0]    FwdReg,
  output logic             FwdHit,
  output logic [DW-1:0]    FwdDat
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] dst_q [DEPTH];
  logic [DW-1:0] dat_q [DEPTH];
  logic [PW-1:0] head, tail, alu_slot, idx;
  logic [CW-1:0] count, free;
  logic          pop, mem_push, alu_push;

  // free already credits the head retiring on this same edge
  assign pop      = (count != '0);
  assign free     = CW'(DEPTH) - count + CW'(pop);
  assign AluReady = (free >= (CW'(1) + CW'(MemValid)));
  assign mem_push = MemValid;
  assign alu_push = AluValid & AluReady;
  assign alu_slot = tail + PW'(mem_push);

  assign Wen  = pop;
  assign Wd   = pop ? dst_q[head] : '0;
  assign Wdat = pop ? dat_q[head] : '0;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(mem_push) + PW'(alu_push);
      count <= count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
    end
  end

  // Load goes in first so it is older than a same-cycle ALU result
  always_ff @(posedge Clk) begin
    if (mem_push) begin
      dst_q[tail] <= MemDst;
      dat_q[tail] <= MemDat;
    end
    if (alu_push) begin
      dst_q[alu_slot] <= AluDst;
      dat_q[alu_slot] <= AluDat;
    end
  end

  // Walk oldest to youngest so the last match left in FwdDat is the youngest
  always_comb begin
    Busy   = '0;
    FwdHit = 1'b0;
    FwdDat = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count) begin
        Busy[dst_q[idx]] = 1'b1;
        if (dst_q[idx] == FwdReg) begin
          FwdHit = 1'b1;
          FwdDat = dat_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - randomized and directed checks of wb_queue against a queue model
module tb_wb_queue;

  localparam int DEPTH = 4;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       AluValid, MemValid, AluReady, Wen, FwdHit;
  logic [2:0] AluDst, MemDst, Wd, FwdReg;
  logic [7:0] AluDat, MemDat, Wdat, FwdDat, Busy;

  logic [7:0]  core  [8];
  logic [7:0]  mcore [8];
  logic [10:0] mq [$];
  int vectors = 0;
  int miscompares = 0;

  wb_queue #(.DEPTH(DEPTH), .AW(3), .DW(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .AluValid(AluValid), .AluDst(AluDst), .AluDat(AluDat), .AluReady(AluReady),
    .MemValid(MemValid), .MemDst(MemDst), .MemDat(MemDat),
    .Wen(Wen), .Wd(Wd), .Wdat(Wdat), .Busy(Busy),
    .FwdReg(FwdReg), .FwdHit(FwdHit), .FwdDat(FwdDat)
  );

  always #5 Clk = ~Clk;

  // Register file stand-in driven only by the write port
  always @(posedge Clk) if (Wen) core[Wd] <= Wdat;

  function automatic logic [63:0] pack_rf(input logic [7:0] a [8]);
    logic [63:0] p;
    for (int k = 0; k < 8; k++) p[k*8 +: 8] = a[k];
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    MemValid = 1'b0; MemDst = '0; MemDat = '0;
    AluValid = 1'b0; AluDst = '0; AluDat = '0;
  endtask

  task automatic step(input logic mv, input logic [2:0] md, input logic [7:0] mx,
                      input logic av, input logic [2:0] ad, input logic [7:0] ax,
                      input logic [2:0] fr);
    logic [7:0] ebusy, efd;
    logic       ehit, erdy;
    int         n;
    MemValid = mv; MemDst = md; MemDat = mx;
    AluValid = av; AluDst = ad; AluDat = ax;
    FwdReg = fr;
    #1;
    n = mq.size();
    ebusy = '0; ehit = 1'b0; efd = '0;
    foreach (mq[k]) begin
      ebusy[mq[k][10:8]] = 1'b1;
      if (mq[k][10:8] == fr) begin
        ehit = 1'b1;
        efd  = mq[k][7:0];
      end
    end
    erdy = ((DEPTH - n + ((n != 0) ? 1 : 0)) >= (1 + (mv ? 1 : 0)));
    chk("wen", 64'(Wen), 64'(n != 0));
    if (n != 0) begin
      chk("wd", 64'(Wd), 64'(mq[0][10:8]));
      chk("wdat", 64'(Wdat), 64'(mq[0][7:0]));
    end
    chk("busy", 64'(Busy), 64'(ebusy));
    chk("fwdhit", 64'(FwdHit), 64'(ehit));
    chk("fwddat", 64'(FwdDat), 64'(efd));
    chk("aluready", 64'(AluReady), 64'(erdy));
    @(posedge Clk);
    if (n != 0) begin
      mcore[mq[0][10:8]] = mq[0][7:0];
      void'(mq.pop_front());
    end
    if (mv) mq.push_back({md, mx});
    if (av && erdy) mq.push_back({ad, ax});
    #1;
    chk("core", pack_rf(core), pack_rf(mcore));
    idle_inputs();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wen"}, 64'(Wen), 64'd0);
    chk({tag, "_busy"}, 64'(Busy), 64'd0);
    chk({tag, "_fwdhit"}, 64'(FwdHit), 64'd0);
    chk({tag, "_fwddat"}, 64'(FwdDat), 64'd0);
    chk({tag, "_aluready"}, 64'(AluReady), 64'd1);
    chk({tag, "_wd"}, 64'(Wd), 64'd0);
  endtask

  initial begin
    Reset_n = 1'b0;
    FwdReg  = '0;
    idle_inputs();
    repeat (2) @(posedge Clk);
    #1;
    check_reset_outputs("reset");
    mq.delete();
    Reset_n = 1'b1;

    // Idle: nothing may reach the register file
    repeat (5) step(0, 0, 0, 0, 0, 0, 3'd1);

    // Single ALU write
    step(0, 0, 0, 1, 3'd6, 8'd10, 3'd6);
    chk("single_busy", 64'(Busy), 64'h40);
    step(0, 0, 0, 0, 0, 0, 3'd6);
    chk("single_core6", 64'(core[6]), 64'd10);

    // Simultaneous producers to the same register
    step(1, 3'd2, 8'd96, 1, 3'd2, 8'd31, 3'd2);
    chk("simul_fwd", 64'(FwdDat), 64'd31);
    step(0, 0, 0, 0, 0, 0, 3'd2);
    chk("simul_first", 64'(core[2]), 64'd96);
    step(0, 0, 0, 0, 0, 0, 3'd2);
    chk("simul_final", 64'(core[2]), 64'd31);
    repeat (2) step(0, 0, 0, 0, 0, 0, 3'd0);

    // Fill with a load every cycle; the fourth ALU push meets a full queue
    for (int r = 1; r <= 4; r++) step(1, 3'd7, 8'(r), 1, 3'(r), 8'(r * 16), 3'(r));
    MemValid = 1'b1; #1;
    chk("full_backpressure", 64'(AluReady), 64'd0);
    idle_inputs();
    // Full plus load: load accepted, ALU rejected
    step(1, 3'd7, 8'd5, 1, 3'd3, 8'h77, 3'd7);
    repeat (3) step(0, 0, 0, 0, 0, 0, 3'd7);
    chk("load_pending", 64'(Wd), 64'd7);
    chk("load_pending_dat", 64'(Wdat), 64'd5);
    repeat (3) step(0, 0, 0, 0, 0, 0, 3'd7);
    chk("load_core7", 64'(core[7]), 64'd5);
    chk("load_core3", 64'(core[3]), 64'h30);

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      step(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 8'($urandom),
           ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
           3'($urandom_range(0, 7)));
    end
    repeat (6) step(0, 0, 0, 0, 0, 0, 3'd0);

    // Reset mid-queue with regs 3, 4, 5 queued
    step(1, 3'd1, 8'hAA, 1, 3'd3, 8'h11, 3'd3);
    step(1, 3'd4, 8'h22, 1, 3'd5, 8'h33, 3'd4);
    chk("midq_busy", 64'(Busy), 64'h38);
    #3;
    Reset_n = 1'b0;
    #1;
    check_reset_outputs("midq");
    mq.delete();
    @(posedge Clk);
    #1;
    chk("midq_core", pack_rf(core), pack_rf(mcore));
    chk("midq_core4", 64'(core[4]), 64'(mcore[4]));
    chk("midq_core5", 64'(core[5]), 64'(mcore[5]));
    Reset_n = 1'b1;
    repeat (3) step(0, 0, 0, 0, 0, 0, 3'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
